// File: rtl/cm0_dap_ap_cdc.sv
// AP-side responder of the DP/AP toggle handshake: synchronises the DP request,
// runs one access on the AP engine and returns data, error and a toggled ack.
module cm0_dap_ap_cdc #(
  parameter bit PRESENT = 1'b1,
  parameter bit RAR     = 1'b0
) (
  input  logic        dclk,
  input  logic        apreset_n,
  input  logic [37:0] cm0_dap_dp_to_ap,
  output logic [33:0] cm0_dap_ap_to_dp,
  output logic        ap_req_o,
  output logic        ap_write_o,
  output logic [3:0]  ap_addr_o,
  output logic [31:0] ap_wdata_o,
  input  logic [31:0] ap_rdata_i,
  input  logic        ap_ready_i,
  input  logic        ap_slverr_i,
  input  logic        SE
);

  logic unused_se;
  assign unused_se = SE;

  if (PRESENT) begin : g_present
    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic        req_sync1_q, req_sync2_q;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        rnw_q, rnw_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic        capture;

    always_ff @(posedge dclk or negedge apreset_n) begin
      if (!apreset_n) begin
        req_sync1_q <= 1'b0;
        req_sync2_q <= 1'b0;
        ack_q       <= 1'b0;
        err_q       <= 1'b0;
        state_q     <= StIdle;
      end else begin
        req_sync1_q <= cm0_dap_dp_to_ap[0];
        req_sync2_q <= req_sync1_q;
        ack_q       <= ack_d;
        err_q       <= err_d;
        state_q     <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      err_d   = err_q;
      data_d  = data_q;
      capture = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_sync2_q != ack_q) begin
            capture = 1'b1;
            state_d = StAccess;
          end
        end
        StAccess: begin
          if (ap_ready_i) begin
            err_d   = ap_slverr_i;
            state_d = StDone;
            if (rnw_q) data_d = ap_rdata_i;
          end
        end
        StDone: begin
          ack_d   = ~ack_q;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    // Fields 37:1 are quasi-static: the DP holds them while req != ack.
    assign rnw_d   = capture ? cm0_dap_dp_to_ap[37]    : rnw_q;
    assign addr_d  = capture ? cm0_dap_dp_to_ap[36:33] : addr_q;
    assign wdata_d = capture ? cm0_dap_dp_to_ap[32:1]  : wdata_q;

    if (RAR) begin : g_rar
      always_ff @(posedge dclk or negedge apreset_n) begin
        if (!apreset_n) begin
          rnw_q   <= 1'b0;
          addr_q  <= 4'h0;
          wdata_q <= 32'h0;
          data_q  <= 32'h0;
        end else begin
          rnw_q   <= rnw_d;
          addr_q  <= addr_d;
          wdata_q <= wdata_d;
          data_q  <= data_d;
        end
      end
    end else begin : g_norar
      always_ff @(posedge dclk) begin
        rnw_q   <= rnw_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        data_q  <= data_d;
      end
    end

    assign cm0_dap_ap_to_dp = {data_q, err_q, ack_q};
    assign ap_req_o         = (state_q == StAccess);
    assign ap_write_o       = ~rnw_q;
    assign ap_addr_o        = addr_q;
    assign ap_wdata_o       = wdata_q;
  end else begin : g_absent
    logic unused_in;
    assign unused_in = ^{dclk, apreset_n, cm0_dap_dp_to_ap, ap_rdata_i, ap_ready_i,
                         ap_slverr_i};

    assign cm0_dap_ap_to_dp = 34'h0;
    assign ap_req_o         = 1'b0;
    assign ap_write_o       = 1'b0;
    assign ap_addr_o        = 4'h0;
    assign ap_wdata_o       = 32'h0;
  end

endmodule

// File: tb/tb_cm0_dap_ap_cdc.sv
// Directed bench for cm0_dap_ap_cdc: read, write with error, zero-wait burst,
// reset mid-access, stray ready, and a PRESENT=0 instance held at zero.
module tb_cm0_dap_ap_cdc;
  logic        dclk = 1'b0;
  logic        apreset_n;
  logic        rnw, req;
  logic [3:0]  regaddr;
  logic [31:0] dp_data;
  logic [37:0] dp_to_ap;
  logic [31:0] ap_rdata;
  logic        ap_ready, ap_slverr, se;

  logic [33:0] ap_to_dp, ap_to_dp0;
  logic        req_o, write_o, req_o0, write_o0;
  logic [3:0]  addr_o, addr_o0;
  logic [31:0] wdata_o, wdata_o0;

  int checks = 0;
  int failures = 0;

  assign dp_to_ap = {rnw, regaddr, dp_data, req};

  always #5 dclk = ~dclk;

  cm0_dap_ap_cdc #(.PRESENT(1'b1), .RAR(1'b1)) dut (
    .dclk(dclk), .apreset_n(apreset_n), .cm0_dap_dp_to_ap(dp_to_ap),
    .cm0_dap_ap_to_dp(ap_to_dp), .ap_req_o(req_o), .ap_write_o(write_o),
    .ap_addr_o(addr_o), .ap_wdata_o(wdata_o), .ap_rdata_i(ap_rdata),
    .ap_ready_i(ap_ready), .ap_slverr_i(ap_slverr), .SE(se)
  );

  cm0_dap_ap_cdc #(.PRESENT(1'b0), .RAR(1'b0)) dut0 (
    .dclk(dclk), .apreset_n(apreset_n), .cm0_dap_dp_to_ap(dp_to_ap),
    .cm0_dap_ap_to_dp(ap_to_dp0), .ap_req_o(req_o0), .ap_write_o(write_o0),
    .ap_addr_o(addr_o0), .ap_wdata_o(wdata_o0), .ap_rdata_i(ap_rdata),
    .ap_ready_i(ap_ready), .ap_slverr_i(ap_slverr), .SE(se)
  );

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int acc_cnt, ack_cnt, prev_ack;

    apreset_n = 1'b0;
    rnw = 1'b0; req = 1'b0; regaddr = 4'h0; dp_data = 32'h0;
    ap_rdata = 32'h0; ap_ready = 1'b0; ap_slverr = 1'b0; se = 1'b0;
    tick(); tick();
    check("reset_bus", {30'h0, ap_to_dp}, 64'h0);
    check("reset_req", {63'h0, req_o}, 64'h0);
    check("reset_addr", {60'h0, addr_o}, 64'h0);
    check("reset_wdata", {32'h0, wdata_o}, 64'h0);
    apreset_n = 1'b1;
    tick();

    // Read: req 0->1, ready after 3 ACCESS cycles
    rnw = 1'b1; regaddr = 4'hC; dp_data = 32'h0BAD_F00D; req = 1'b1;
    tick(); tick();
    check("rd_req_early", {63'h0, req_o}, 64'h0);
    tick();
    check("rd_req_n3", {63'h0, req_o}, 64'h1);
    check("rd_write", {63'h0, write_o}, 64'h0);
    check("rd_addr", {60'h0, addr_o}, 64'hC);
    tick(); tick();
    ap_rdata = 32'hDEAD_BEEF; ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0; ap_rdata = 32'h0;
    check("rd_req_drop", {63'h0, req_o}, 64'h0);
    check("rd_bus_m1", {30'h0, ap_to_dp}, {30'h0, 32'hDEAD_BEEF, 1'b0, 1'b0});
    tick();
    check("rd_bus_m2", {30'h0, ap_to_dp}, {30'h0, 32'hDEAD_BEEF, 1'b0, 1'b1});

    // Write with error: req 1->0
    rnw = 1'b0; regaddr = 4'h4; dp_data = 32'h1234_5678; req = 1'b0;
    tick(); tick(); tick();
    check("wr_req", {63'h0, req_o}, 64'h1);
    check("wr_write", {63'h0, write_o}, 64'h1);
    check("wr_addr", {60'h0, addr_o}, 64'h4);
    check("wr_wdata", {32'h0, wdata_o}, 64'h1234_5678);
    ap_rdata = 32'hCAFE_F00D; ap_ready = 1'b1; ap_slverr = 1'b1;
    tick();
    ap_ready = 1'b0; ap_slverr = 1'b0;
    check("wr_bus_m1", {30'h0, ap_to_dp}, {30'h0, 32'hDEAD_BEEF, 1'b1, 1'b1});
    tick();
    check("wr_bus_m2", {30'h0, ap_to_dp}, {30'h0, 32'hDEAD_BEEF, 1'b1, 1'b0});

    // Zero-wait, 8 alternating requests
    ap_ready = 1'b1; rnw = 1'b0;
    acc_cnt = 0; ack_cnt = 0; prev_ack = int'(ap_to_dp[0]);
    for (int i = 0; i < 8; i++) begin
      dp_data = 32'hA000_0000 + i;
      req = ~req;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (req_o) begin
          acc_cnt++;
          check("b2b_wdata", {32'h0, wdata_o}, {32'h0, 32'hA000_0000 + i});
        end
        if (int'(ap_to_dp[0]) != prev_ack) begin
          ack_cnt++;
          prev_ack = int'(ap_to_dp[0]);
        end
        if (ap_to_dp[0] == req) break;
      end
      check("b2b_acked", {63'h0, ap_to_dp[0]}, {63'h0, req});
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (req_o) acc_cnt++;
      if (int'(ap_to_dp[0]) != prev_ack) begin
        ack_cnt++;
        prev_ack = int'(ap_to_dp[0]);
      end
    end
    check("b2b_accesses", 64'(acc_cnt), 64'd8);
    check("b2b_acks", 64'(ack_cnt), 64'd8);
    check("b2b_err", {63'h0, ap_to_dp[1]}, 64'h0);

    // Reset mid-access
    ap_ready = 1'b0; req = ~req;
    tick(); tick(); tick();
    check("rst_in_access", {63'h0, req_o}, 64'h1);
    apreset_n = 1'b0;
    #1;
    check("rst_req", {63'h0, req_o}, 64'h0);
    check("rst_bus", {30'h0, ap_to_dp}, 64'h0);
    tick();
    apreset_n = 1'b1;
    check("rst_reqbit", {63'h0, req}, 64'h1);
    rnw = 1'b1; regaddr = 4'h8;
    ap_rdata = 32'hA5A5_A5A5;
    acc_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (req_o) begin
        acc_cnt++;
        ap_ready = 1'b1;
      end
    end
    check("rst_one_access", 64'(acc_cnt), 64'd1);
    check("rst_bus_after", {30'h0, ap_to_dp}, {30'h0, 32'hA5A5_A5A5, 1'b0, 1'b1});

    // Stray ready in IDLE
    ap_rdata = 32'h1111_1111; ap_slverr = 1'b1; ap_ready = 1'b1;
    tick(); tick(); tick(); tick();
    ap_ready = 1'b0; ap_slverr = 1'b0;
    check("stray_req", {63'h0, req_o}, 64'h0);
    check("stray_bus", {30'h0, ap_to_dp}, {30'h0, 32'hA5A5_A5A5, 1'b0, 1'b1});

    // PRESENT=0 instance under random stimulus
    for (int c = 0; c < 20; c++) begin
      {rnw, regaddr} = 5'($urandom);
      dp_data = $urandom; req = 1'($urandom);
      ap_rdata = $urandom; ap_ready = 1'($urandom); ap_slverr = 1'($urandom);
      se = 1'($urandom);
      tick();
      check("absent_outputs", {ap_to_dp0, req_o0, write_o0, addr_o0, wdata_o0[19:0]}, 64'h0);
      check("absent_wdata", {32'h0, wdata_o0}, 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cm0_dap_ap_cdc.md
Name: cm0_dap_ap_cdc

Overview:
AP half of the DP/AP clock-domain crossing; the responder end of the request/acknowledge handshake driven by the DP.
- Receives the packed DP-to-AP bus, synchronises the toggle request into the AP clock domain and captures the access fields.
- Issues one access to the AP register/bus engine.
- Returns read data, an error flag and a toggled acknowledge on the packed AP-to-DP bus.

Parameters:
PRESENT, 1, 1 = block implemented; 0 = all outputs tied to 0 and no flops inferred.
RAR, 0, 1 = every flop has a reset; 0 = only the synchroniser, state and ack/req flops are reset, datapath capture registers are not.

Ports:
dclk  input  1  AP-domain clock.
apreset_n  input  1  Asynchronous active-low reset, AP domain.
cm0_dap_dp_to_ap  input  38  {dp_rnw[37], dp_regaddr[36:33], dp_data[32:1], dp_req_dp[0]}; bit 0 is the toggle request, asynchronous to dclk.
cm0_dap_ap_to_dp  output  34  {ap_data[33:2], ap_err[1], ap_ack_ap[0]}.
ap_req_o  output  1  Access request level to the AP engine.
ap_write_o  output  1  1 = write, 0 = read; equals captured ~dp_rnw.
ap_addr_o  output  4  Captured dp_regaddr.
ap_wdata_o  output  32  Captured dp_data.
ap_rdata_i  input  32  Read data, valid with ap_ready_i.
ap_ready_i  input  1  Access complete, sampled only in ACCESS.
ap_slverr_i  input  1  Access error, valid with ap_ready_i.
SE  input  1  Scan enable; no functional effect, reserved for DFT.

Behaviour:
Reset values:
- req_sync1 = 0, req_sync2 = 0, ack_ap = 0.
- State = IDLE, ap_req_o = 0, ap_err = 0.
- ap_data = 0 and the captured fields = 0 when RAR = 1; unspecified otherwise.

Synchroniser:
- Bit 0 of cm0_dap_dp_to_ap passes through a 2-flop synchroniser to give req_sync2.
- Bits 37:1 are not synchronised. The DP holds them stable while req differs from ack.

Pending condition: pending = (req_sync2 != ack_ap).

State machine:
- IDLE: if pending, capture rnw, regaddr and data, then go to ACCESS. Otherwise remain in IDLE.
- ACCESS: ap_req_o = 1 and ap_write_o/ap_addr_o/ap_wdata_o are held stable.
  - On ap_ready_i = 1 for a read: ap_data <= ap_rdata_i.
  - On ap_ready_i = 1 for a write: ap_data is unchanged.
  - On ap_ready_i = 1 in both cases: ap_err <= ap_slverr_i, ap_req_o deasserts next cycle, go to DONE.
- DONE: ack_ap <= ~ack_ap and go to IDLE. ap_data/ap_err are therefore stable at least 1 dclk before ack toggles.

Latency:
- Request toggle at the input in cycle n: req_sync2 changes at n+2, capture happens at n+2, ap_req_o = 1 from n+3.
- With ap_ready_i high in cycle m, the ack toggle is visible at m+2.

Handshake rules:
- Exactly one access per request toggle. ap_req_o is a level held until ready; no back-to-back pulses.
- If a new toggle arrives while busy, it is seen as pending on the return to IDLE. The DP never does this legally.
- ap_ready_i outside ACCESS is ignored.
- ap_err updates on every completion; there is no sticky behaviour here.

Boundary conditions:
- If req_sync2 re-equals ack_ap mid-access (DP reset), the access completes and ack still toggles. The DP's handshake-reset logic absorbs the resulting mismatch.
- ap_ready_i high in the first ACCESS cycle gives the minimum path: ACCESS for 1 cycle.
- apreset_n asserted at any time forces the reset values immediately, including abandoning an in-flight ACCESS with ap_req_o = 0.
- PRESENT = 0: cm0_dap_ap_to_dp = 0, ap_req_o = 0, ap_write_o = 0, ap_addr_o = 0, ap_wdata_o = 0.

Test Plan:
- Read: bus = {rnw=1, regaddr=4'hC, data=x, req 0->1}, engine returns ap_rdata_i=32'hDEADBEEF with ready after 3 cycles and slverr=0 -> ap_req_o asserted 3 cycles after the toggle with ap_write_o=0, ap_addr_o=4'hC; then ap_data=32'hDEADBEEF, ap_err=0, and ap_ack_ap 0->1 two cycles after ready.
- Write with error: {rnw=0, regaddr=4'h4, data=32'h12345678, req 1->0}, ready with slverr=1 -> ap_write_o=1, ap_wdata_o=32'h12345678; ap_err=1, ap_data unchanged, ack 1->0.
- Zero-wait and back-to-back: ready tied high, 8 alternating requests -> exactly 8 ap_req_o assertions, 8 ack toggles, no lost or duplicate access.
- Reset mid-access: assert apreset_n low while in ACCESS -> ap_req_o = 0, ack = 0, state IDLE. After release with req bit = 1, one new access occurs.
- Stray ready: ap_ready_i pulsed in IDLE -> ap_data, ap_err and ack unchanged.
- PRESENT=0 build: random stimulus -> all outputs remain 0.
